// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle for the ring/Johnson counter.
// The master drives the controls and observes state; the counter itself is the slave.
interface ring_johnson_counter_if #(
    parameter int N = 5
);
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [N-1:0] load_val;
    logic [N-1:0] q;
    logic         tc;
    logic         err;

    modport master (
        output en, mode, dir, load, load_val,
        input  q, tc, err
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output q, tc, err
    );
endinterface

// File: rtl/ring_johnson_counter.sv
// N-stage shift-register counter running as a one-hot ring or a twisted (Johnson) ring,
// with up/down shifting, validated parallel load, terminal count and an error pulse.
module ring_johnson_counter #(
    parameter int N = 5
) (
    input  logic                   clk_i,
    input  logic                   clear_ni,
    ring_johnson_counter_if.slave  bus
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    localparam logic [N-1:0] RING_SEED    = N'(1);
    localparam logic [N-1:0] JOHNSON_SEED = '0;
    localparam logic [N-1:0] MSB_ONLY     = {1'b1, {(N-1){1'b0}}};

    mode_e        mode_q, mode_d;
    logic [N-1:0] q_q, q_d;
    logic         err_q, err_d;

    mode_e        modeIn;
    logic [N-1:0] seed;
    logic [N-1:0] shifted;
    logic         stateLegal;
    logic         loadLegal;
    logic         lastState;

    function automatic logic ringLegal(input logic [N-1:0] v);
        return $onehot(v);
    endfunction

    // Johnson states are a block of ones against a block of zeros, in either order.
    function automatic logic johnsonLegal(input logic [N-1:0] v);
        logic [N-1:0] inv;
        inv = ~v;
        return ((v & (v + N'(1))) == '0) || ((inv & (inv + N'(1))) == '0);
    endfunction

    function automatic logic legalFor(input mode_e m, input logic [N-1:0] v);
        return (m == MODE_JOHNSON) ? johnsonLegal(v) : ringLegal(v);
    endfunction

    assign modeIn     = mode_e'(bus.mode);
    assign seed       = (modeIn == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;
    assign stateLegal = legalFor(mode_q, q_q);
    assign loadLegal  = legalFor(modeIn, bus.load_val);

    always_comb begin
        shifted = q_q;
        unique case ({mode_q == MODE_JOHNSON, bus.dir})
            2'b00:   shifted = {q_q[N-2:0], q_q[N-1]};
            2'b01:   shifted = {q_q[0], q_q[N-1:1]};
            2'b10:   shifted = {q_q[N-2:0], ~q_q[N-1]};
            default: shifted = {~q_q[0], q_q[N-1:1]};
        endcase
    end

    always_comb begin
        lastState = 1'b0;
        if (mode_q == MODE_JOHNSON)
            lastState = bus.dir ? (q_q == RING_SEED) : (q_q == MSB_ONLY);
        else
            lastState = bus.dir ? q_q[0] : q_q[N-1];
    end

    // A mode change always reseeds, so any pending load or shift that edge is discarded.
    always_comb begin
        mode_d = modeIn;
        q_d    = q_q;
        err_d  = 1'b0;
        if (modeIn != mode_q) begin
            q_d = seed;
        end else if (bus.load) begin
            if (loadLegal) begin
                q_d = bus.load_val;
            end else begin
                q_d   = seed;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (stateLegal) begin
                q_d = shifted;
            end else begin
                q_d   = seed;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            mode_q <= MODE_RING;
            q_q    <= RING_SEED;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            q_q    <= q_d;
            err_q  <= err_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.err = err_q;
    assign bus.tc  = bus.en & ~bus.load & (modeIn == mode_q) & lastState;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed, table-driven bench for ring_johnson_counter at N=5, with hand-written
// sequences for asynchronous clear in the middle of a count.
module tb_ring_johnson_counter;

    localparam int N = 5;

    typedef struct {
        logic         en;
        logic         mode;
        logic         dir;
        logic         load;
        logic [N-1:0] loadVal;
        logic         expTc;
        logic [N-1:0] expQ;
        logic         expErr;
    } vec_t;

    logic clk;
    logic clear_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    ring_johnson_counter_if #(.N(N)) bus ();

    ring_johnson_counter #(.N(N)) dut (
        .clk_i    (clk),
        .clear_ni (clear_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic addVec(input logic en, input logic mode, input logic dir, input logic load,
                          input logic [N-1:0] loadVal, input logic expTc,
                          input logic [N-1:0] expQ, input logic expErr);
        vec_t v;
        v.en = en; v.mode = mode; v.dir = dir; v.load = load; v.loadVal = loadVal;
        v.expTc = expTc; v.expQ = expQ; v.expErr = expErr;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; tc is checked just before the rising edge,
    // q and err just after it.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        bus.en       = v.en;
        bus.mode     = v.mode;
        bus.dir      = v.dir;
        bus.load     = v.load;
        bus.load_val = v.loadVal;
        #1;
        checkOutput({tag, " tc"}, N'(bus.tc), N'(v.expTc));
        @(posedge clk);
        #1;
        checkOutput({tag, " q"}, bus.q, v.expQ);
        checkOutput({tag, " err"}, N'(bus.err), N'(v.expErr));
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;

        // ring up through a full revolution
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b00010, 0);
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b00100, 0);
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b01000, 0);
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b10000, 0);
        addVec(1, 0, 0, 0, 5'b00000, 1, 5'b00001, 0);
        // switch to Johnson, then count up through all 10 states
        addVec(0, 1, 0, 0, 5'b00000, 0, 5'b00000, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b00001, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b00011, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b00111, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b01111, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b11111, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b11110, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b11100, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b11000, 0);
        addVec(1, 1, 0, 0, 5'b00000, 0, 5'b10000, 0);
        addVec(1, 1, 0, 0, 5'b00000, 1, 5'b00000, 0);
        // back to ring with en high: reseed wins, tc suppressed
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b00001, 0);
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b00010, 0);
        addVec(1, 0, 0, 0, 5'b00000, 0, 5'b00100, 0);
        // ring down and wrap, then reverse every cycle
        addVec(1, 0, 1, 0, 5'b00000, 0, 5'b00010, 0);
        addVec(1, 0, 1, 0, 5'b00000, 0, 5'b00001, 0);
        addVec(1, 0, 1, 0, 5'b00000, 1, 5'b10000, 0);
        addVec(1, 0, 0, 0, 5'b00000, 1, 5'b00001, 0);
        addVec(1, 0, 1, 0, 5'b00000, 1, 5'b10000, 0);
        // loads: rejected ring load, err lasts one cycle, Johnson legal/illegal loads
        addVec(0, 0, 0, 1, 5'b00110, 0, 5'b00001, 1);
        addVec(0, 0, 0, 0, 5'b00000, 0, 5'b00001, 0);
        addVec(0, 1, 0, 0, 5'b00000, 0, 5'b00000, 0);
        addVec(0, 1, 0, 1, 5'b11100, 0, 5'b11100, 0);
        addVec(0, 1, 0, 1, 5'b10100, 0, 5'b00000, 1);
        // Johnson down, all-ones load, down terminal state
        addVec(1, 1, 1, 0, 5'b00000, 0, 5'b10000, 0);
        addVec(1, 1, 1, 0, 5'b00000, 0, 5'b11000, 0);
        addVec(0, 1, 0, 1, 5'b11111, 0, 5'b11111, 0);
        addVec(1, 1, 1, 0, 5'b00000, 0, 5'b01111, 0);
        addVec(0, 1, 0, 1, 5'b00001, 0, 5'b00001, 0);
        addVec(1, 1, 1, 0, 5'b00000, 1, 5'b00000, 0);
        // mode change beats a simultaneous load
        addVec(0, 0, 0, 1, 5'b00100, 0, 5'b00001, 0);
        // all-zero is not a ring state
        addVec(0, 0, 0, 1, 5'b00000, 0, 5'b00001, 1);
        // load and en together: load only, no shift
        addVec(1, 0, 0, 1, 5'b01000, 0, 5'b01000, 0);

        clear_n      = 1'b0;
        bus.en       = 1'b0;
        bus.mode     = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset q", bus.q, 5'b00001);
        checkOutput("reset err", N'(bus.err), 5'b0);
        checkOutput("reset tc", N'(bus.tc), 5'b0);
        clear_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // asynchronous clear between edges while q=01000
        @(negedge clk);
        bus.en   = 1'b0;
        bus.load = 1'b0;
        #2;
        clear_n = 1'b0;
        #1;
        checkOutput("midclear q", bus.q, 5'b00001);
        checkOutput("midclear err", N'(bus.err), 5'b0);
        clear_n = 1'b1;
        v = '{en: 1, mode: 0, dir: 0, load: 0, loadVal: '0, expTc: 0, expQ: 5'b00010, expErr: 0};
        applyStimulus(v, "postclear");

        // clear released with Johnson requested: first edge reseeds to zero
        @(negedge clk);
        clear_n  = 1'b0;
        bus.mode = 1'b1;
        bus.en   = 1'b0;
        #1;
        checkOutput("clear2 q", bus.q, 5'b00001);
        clear_n = 1'b1;
        v = '{en: 0, mode: 1, dir: 0, load: 0, loadVal: '0, expTc: 0, expQ: 5'b00000, expErr: 0};
        applyStimulus(v, "clear2 reseed");
        v = '{en: 1, mode: 1, dir: 0, load: 0, loadVal: '0, expTc: 0, expQ: 5'b00001, expErr: 0};
        applyStimulus(v, "clear2 count");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
